// File: rtl/hpdcache_sram_wbe_ctrl_pkg.sv
//==============================================================================
// Module      : hpdcache_sram_ctrl_pkg
// Description : Shared types and constants for the byte-write-enable SRAM
//               controller and its response FIFO.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package hpdcache_sram_ctrl_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    localparam int unsigned c_rsp_fifo_depth = 2;

    // Row data / byte-enable widths; the row types themselves are declared in
    // each module from its own parameters using these helpers.
    function automatic int unsigned row_width(input int unsigned ndata,
                                              input int unsigned data_size);
        return ndata * data_size;
    endfunction

    function automatic int unsigned row_wbe_width(input int unsigned ndata,
                                                  input int unsigned data_size);
        return (ndata * data_size) / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hpdcache_sram_wbe_ctrl_if.sv
//==============================================================================
// Module      : hpdcache_sram_wbe_ctrl_if
// Description : Request, response and SRAM-side signal bundle of the
//               byte-write-enable SRAM controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface hpdcache_sram_wbe_ctrl_if #(
    parameter int unsigned ADDR_SIZE = 6,
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned NDATA     = 1
);
    localparam int unsigned c_row_w = NDATA * DATA_SIZE;
    localparam int unsigned c_wbe_w = c_row_w / 8;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [c_row_w-1:0]   req_wdata;
    logic [c_wbe_w-1:0]   req_wbe;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [c_row_w-1:0]   rsp_rdata;

    logic                 sram_cs;
    logic                 sram_we;
    logic [ADDR_SIZE-1:0] sram_addr;
    logic [c_row_w-1:0]   sram_wdata;
    logic [c_wbe_w-1:0]   sram_wbyteenable;
    logic [c_row_w-1:0]   sram_rdata;

    // Initiator / SRAM-wrapper side
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wbe,
        output rsp_ready,
        output sram_rdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata,
        input  sram_cs, sram_we, sram_addr, sram_wdata, sram_wbyteenable
    );

    // Controller side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wbe,
        input  rsp_ready,
        input  sram_rdata,
        output req_ready,
        output rsp_valid, rsp_rdata,
        output sram_cs, sram_we, sram_addr, sram_wdata, sram_wbyteenable
    );

endinterface

`default_nettype wire

// File: rtl/hpdcache_sram_wbe_ctrl_rsp_fifo.sv
//==============================================================================
// Module      : hpdcache_sram_ctrl_rsp_fifo
// Description : Two-entry registered FIFO holding SRAM read data until the
//               consumer takes it; valid output is registered.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hpdcache_sram_ctrl_rsp_fifo #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [1:0]       o_count
);
    import hpdcache_sram_ctrl_pkg::*;

    logic [WIDTH-1:0] r_mem [c_rsp_fifo_depth];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             r_valid;
    logic [1:0]       w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        case ({i_push, i_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // One-bit pointers wrap naturally at the two-entry depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            if (i_push) r_wptr <= ~r_wptr;
            if (i_pop)  r_rptr <= ~r_rptr;
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_valid = r_valid;
    assign o_count = r_count;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && (r_count == 2'd2)))
        else $fatal(1, "rsp fifo overflow: push while full");
`endif

endmodule

`default_nettype wire

// File: rtl/hpdcache_sram_wbe_ctrl.sv
//==============================================================================
// Module      : hpdcache_sram_wbe_ctrl
// Description : Initiator-side controller for a 1RW byte-write-enable SRAM with
//               credit-protected 2-entry read response buffer.
//               Optional macro HPDCACHE_SRAM_CTRL_INIT_EN: zero-fill sweep of
//               all rows after reset before accepting requests.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hpdcache_sram_wbe_ctrl #(
    parameter int unsigned ADDR_SIZE = 6,
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned DEPTH     = 2**ADDR_SIZE,
    parameter int unsigned NDATA     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    hpdcache_sram_wbe_ctrl_if.slave bus
);
    import hpdcache_sram_ctrl_pkg::*;

    localparam int unsigned c_row_w = row_width(NDATA, DATA_SIZE);
    localparam int unsigned c_wbe_w = row_wbe_width(NDATA, DATA_SIZE);

    typedef logic [c_row_w-1:0] row_t;
    typedef logic [c_wbe_w-1:0] wbe_t;

    if ((DEPTH == 0) || (DEPTH > 2**ADDR_SIZE) || ((DATA_SIZE % 8) != 0)) begin : g_param_check
        $error("hpdcache_sram_wbe_ctrl: illegal DEPTH or DATA_SIZE");
    end

`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
    localparam ctrl_state_e          c_reset_state = INIT;
    localparam logic [ADDR_SIZE-1:0] c_last_row    = ADDR_SIZE'(DEPTH - 1);
    logic [ADDR_SIZE-1:0] r_init_row;
`else
    localparam ctrl_state_e          c_reset_state = RUN;
`endif

    ctrl_state_e          r_state;
    ctrl_state_e          w_state_nxt;
    logic                 w_run;
    logic                 w_init_acc;
    logic [ADDR_SIZE-1:0] w_init_addr;

    logic                 r_rd_inflight;
    logic                 w_req_ready;
    logic                 w_req_fire;
    logic                 w_rd_fire;
    logic                 w_pop;
    logic [2:0]           w_credit_used;
    logic                 w_credit_ok;
    logic                 w_fifo_valid;
    logic [1:0]           w_fifo_count;
    row_t                 w_fifo_head;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_reset_state;
        else     r_state <= w_state_nxt;
    end

    // Nothing is accepted or driven to the SRAM while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        w_init_acc  = 1'b0;
        case (r_state)
            RUN: w_run = ~rst;
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
            INIT: begin
                w_init_acc = ~rst;
                if (r_init_row == c_last_row) w_state_nxt = RUN;
            end
`endif
            default: ;
        endcase
    end

`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
    always_ff @(posedge clk) begin
        if (rst)                 r_init_row <= '0;
        else if (r_state == INIT) r_init_row <= r_init_row + ADDR_SIZE'(1);
    end
    assign w_init_addr = r_init_row;
`else
    assign w_init_addr = '0;
`endif

    // Reads reserve a FIFO slot at acceptance: in-flight plus buffered, less
    // the entry leaving this cycle, must leave room.
    assign w_pop         = w_fifo_valid & bus.rsp_ready;
    assign w_credit_used = {2'b00, r_rd_inflight} + {1'b0, w_fifo_count} - {2'b00, w_pop};
    assign w_credit_ok   = (w_credit_used < 3'(c_rsp_fifo_depth));
    assign w_req_ready   = w_run & (bus.req_we | w_credit_ok);
    assign w_req_fire    = bus.req_valid & w_req_ready;
    assign w_rd_fire     = w_req_fire & ~bus.req_we;

    always_ff @(posedge clk) begin
        if (rst) r_rd_inflight <= 1'b0;
        else     r_rd_inflight <= w_rd_fire;
    end

    always_comb begin
        bus.sram_cs          = w_req_fire;
        bus.sram_we          = bus.req_we;
        bus.sram_addr        = bus.req_addr;
        bus.sram_wdata       = bus.req_wdata;
        bus.sram_wbyteenable = bus.req_wbe;
        if (w_init_acc) begin
            bus.sram_cs          = 1'b1;
            bus.sram_we          = 1'b1;
            bus.sram_addr        = w_init_addr;
            bus.sram_wdata       = '0;
            bus.sram_wbyteenable = '1;
        end
    end

    hpdcache_sram_ctrl_rsp_fifo #(
        .WIDTH (c_row_w)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_rd_inflight),
        .i_data  (bus.sram_rdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_fifo_valid;
    assign bus.rsp_rdata = w_fifo_head;

endmodule

`default_nettype wire

// File: tb/tb_hpdcache_sram_wbe_ctrl.sv
//==============================================================================
// Module      : tb_hpdcache_sram_wbe_ctrl
// Description : Self-checking bench with SRAM model and response scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hpdcache_sram_wbe_ctrl;

    localparam int unsigned ADDR_SIZE = 6;
    localparam int unsigned DATA_SIZE = 64;
    localparam int unsigned NDATA     = 1;
    localparam int unsigned DEPTH     = 64;

    typedef struct {
        logic [63:0] d;
        int          c;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [63:0] sram_mem [DEPTH];
    logic [63:0] ref_mem  [DEPTH];
    logic [63:0] sram_q;
    beat_t       got_q [$];
    logic [63:0] exp_q [$];
    int          acc_q [$];

    always #5 clk = ~clk;

    hpdcache_sram_wbe_ctrl_if #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE),
        .NDATA     (NDATA)
    ) bus ();

    hpdcache_sram_wbe_ctrl #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH),
        .NDATA     (NDATA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [63:0] pat(input int a);
        return {32'hC0DE_0000 | 32'(a), 32'(a) * 32'h0101_0101};
    endfunction

    // SRAM model: byte-masked write, one-cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.sram_cs) begin
            if (bus.sram_we) begin
                for (int b = 0; b < 8; b++)
                    if (bus.sram_wbyteenable[b])
                        sram_mem[bus.sram_addr][b*8 +: 8] <= bus.sram_wdata[b*8 +: 8];
            end else begin
                sram_q <= sram_mem[bus.sram_addr];
            end
        end
    end
    assign bus.sram_rdata = sram_q;

    // Scoreboard bookkeeping from the request side; responses collected
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
        end else begin
            if (bus.rsp_valid && bus.rsp_ready)
                got_q.push_back('{d: bus.rsp_rdata, c: cyc});
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_we) begin
                    for (int b = 0; b < 8; b++)
                        if (bus.req_wbe[b])
                            ref_mem[bus.req_addr][b*8 +: 8] = bus.req_wdata[b*8 +: 8];
                end else begin
                    exp_q.push_back(ref_mem[bus.req_addr]);
                    acc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wbe   = '0;
    endtask

    // Hold a request until accepted; waited = cycles spent not ready
    task automatic do_req(input logic we, input logic [5:0] a, input logic [63:0] d,
                          input logic [7:0] be, input int budget, output int waited);
        logic acc;
        acc           = 1'b0;
        waited        = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wbe   = be;
        while (!acc && waited < budget) begin
            @(negedge clk);
            if (bus.req_ready) acc = 1'b1;
            else               waited++;
            step();
        end
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL req_accept addr=%0d we=%0b: not accepted within %0d cycles", a, we, budget);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        idle();
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        step();
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b0) begin
            bad++; $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready);
        end
        total++;
        if (bus.sram_cs !== 1'b0) begin
            bad++; $display("FAIL reset_sram_cs got=%b exp=0", bus.sram_cs);
        end
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid);
        end
        step();
        idle();
        rst = 1'b0;
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            total++;
            if ({bus.req_ready, bus.sram_cs, bus.sram_we, bus.sram_wbyteenable, bus.sram_addr, bus.sram_wdata}
                !== {1'b0, 1'b1, 1'b1, 8'hFF, 6'(i), 64'h0}) begin
                bad++;
                $display("FAIL init_row%0d got rdy=%b cs=%b we=%b be=%h addr=%0d wd=%h", i,
                         bus.req_ready, bus.sram_cs, bus.sram_we, bus.sram_wbyteenable,
                         bus.sram_addr, bus.sram_wdata);
            end
            step();
        end
`endif
        @(negedge clk);
        total++;
        if ({bus.req_ready, bus.rsp_valid, bus.sram_cs} !== 3'b100) begin
            bad++;
            $display("FAIL post_reset got rdy=%b rsp_valid=%b cs=%b exp 1 0 0",
                     bus.req_ready, bus.rsp_valid, bus.sram_cs);
        end
        step();
    endtask

    task automatic test_write_read();
        int    w;
        int    n;
        int    acc;
        beat_t b;
        logic [63:0] e;
        bus.rsp_ready = 1'b1;
        do_req(1'b1, 6'h05, 64'h1122334455667788, 8'hFF, 10, w);
        do_req(1'b0, 6'h05, 64'h0, 8'h00, 10, w);
        idle();
        n = 0;
        while (got_q.size() < 1 && n < 20) begin step(); n++; end
        total++;
        if (got_q.size() < 1 || exp_q.size() < 1) begin
            bad++; $display("FAIL wr_rd_timeout got=%0d responses exp=1", got_q.size());
        end else begin
            b   = got_q.pop_front();
            e   = exp_q.pop_front();
            acc = acc_q.pop_front();
            if (b.d !== e) begin
                bad++; $display("FAIL wr_rd_data got=%h exp=%h", b.d, e);
            end
            total++;
            if (b.c - acc != 2) begin
                bad++; $display("FAIL wr_rd_latency got=%0d exp=2", b.c - acc);
            end
        end
    endtask

    task automatic test_partial_write();
        int    w;
        int    n;
        beat_t b;
        logic [63:0] e;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 6'h05;
        bus.req_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
        bus.req_wbe   = 8'h0F;
        @(negedge clk);
        total++;
        if ({bus.req_ready, bus.sram_cs, bus.sram_we, bus.sram_wbyteenable, bus.sram_addr}
            !== {1'b1, 1'b1, 1'b1, 8'h0F, 6'h05}) begin
            bad++;
            $display("FAIL pw_sram_drive got rdy=%b cs=%b we=%b be=%h addr=%h exp 1 1 1 0f 05",
                     bus.req_ready, bus.sram_cs, bus.sram_we, bus.sram_wbyteenable, bus.sram_addr);
        end
        step();
        do_req(1'b0, 6'h05, 64'h0, 8'h00, 10, w);
        idle();
        n = 0;
        while (got_q.size() < 1 && n < 20) begin step(); n++; end
        total++;
        if (got_q.size() < 1 || exp_q.size() < 1) begin
            bad++; $display("FAIL pw_timeout got=%0d responses exp=1", got_q.size());
        end else begin
            b = got_q.pop_front();
            e = exp_q.pop_front();
            void'(acc_q.pop_front());
            if (b.d !== e) begin
                bad++; $display("FAIL pw_scoreboard got=%h exp=%h", b.d, e);
            end
            total++;
            if (b.d !== 64'h11223344AAAAAAAA) begin
                bad++; $display("FAIL pw_data got=%h exp=11223344aaaaaaaa", b.d);
            end
        end
    endtask

    task automatic test_back_to_back();
        int    w;
        int    n;
        int    c0;
        beat_t b;
        logic [63:0] e;
        bus.rsp_ready = 1'b1;
        for (int a = 0; a < 4; a++) begin
            do_req(1'b0, 6'(a), 64'h0, 8'h00, 10, w);
            total++;
            if (w != 0) begin
                bad++; $display("FAIL b2b_ready addr=%0d stalled=%0d exp=0", a, w);
            end
        end
        idle();
        n = 0;
        while (got_q.size() < 4 && n < 20) begin step(); n++; end
        total++;
        if (got_q.size() < 4 || exp_q.size() < 4) begin
            bad++; $display("FAIL b2b_timeout got=%0d responses exp=4", got_q.size());
        end else begin
            c0 = 0;
            for (int i = 0; i < 4; i++) begin
                b = got_q.pop_front();
                e = exp_q.pop_front();
                void'(acc_q.pop_front());
                if (i == 0) c0 = b.c;
                total++;
                if (b.d !== e || b.c != c0 + i) begin
                    bad++;
                    $display("FAIL b2b_rsp%0d got=%h@%0d exp=%h@%0d", i, b.d, b.c, e, c0 + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int    w;
        int    n;
        beat_t b;
        logic [63:0] e;
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 6'd10, 64'h0, 8'h00, 10, w);
        do_req(1'b0, 6'd11, 64'h0, 8'h00, 10, w);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 6'd12;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({bus.req_ready, bus.rsp_valid} !== 2'b01) begin
                bad++;
                $display("FAIL bp_blocked%0d got rdy=%b rsp_valid=%b exp 0 1", k,
                         bus.req_ready, bus.rsp_valid);
            end
            step();
        end
        do_req(1'b1, 6'd20, 64'hFEED_FACE_0BAD_F00D, 8'hFF, 10, w);
        total++;
        if (w != 0) begin
            bad++; $display("FAIL bp_write_accept stalled=%0d exp=0", w);
        end
        bus.rsp_ready = 1'b1;
        do_req(1'b0, 6'd12, 64'h0, 8'h00, 10, w);
        total++;
        if (w != 0) begin
            bad++; $display("FAIL bp_third_read stalled=%0d exp=0", w);
        end
        idle();
        n = 0;
        while (got_q.size() < 3 && n < 20) begin step(); n++; end
        total++;
        if (got_q.size() < 3 || exp_q.size() < 3) begin
            bad++; $display("FAIL bp_timeout got=%0d responses exp=3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                b = got_q.pop_front();
                e = exp_q.pop_front();
                void'(acc_q.pop_front());
                total++;
                if (b.d !== e) begin
                    bad++; $display("FAIL bp_rsp%0d got=%h exp=%h", i, b.d, e);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        int    w;
        int    n;
        int    seen;
        beat_t b;
        logic [63:0] e;
        bus.rsp_ready = 1'b1;
        do_req(1'b0, 6'd7, 64'h0, 8'h00, 10, w);
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_rsp_valid got=%b exp=0", bus.rsp_valid);
        end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen++;
        end
        step();
        total++;
        if (seen != 0 || got_q.size() != 0) begin
            bad++; $display("FAIL rst_mid_flush got valid_cycles=%0d responses=%0d exp 0 0", seen, got_q.size());
        end
        do_req(1'b0, 6'h05, 64'h0, 8'h00, 200, w);
        idle();
        n = 0;
        while (got_q.size() < 1 && n < 20) begin step(); n++; end
        total++;
        if (got_q.size() < 1 || exp_q.size() < 1) begin
            bad++; $display("FAIL rst_mid_after_timeout got=%0d responses exp=1", got_q.size());
        end else begin
            b = got_q.pop_front();
            e = exp_q.pop_front();
            void'(acc_q.pop_front());
            if (b.d !== e) begin
                bad++; $display("FAIL rst_mid_after_data got=%h exp=%h", b.d, e);
            end
        end
    endtask

`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
    task automatic test_init_restart();
        int    w;
        int    n;
        beat_t b;
        idle();
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        @(negedge clk);
        total++;
        if ({bus.sram_cs, bus.sram_addr} !== {1'b1, 6'd20}) begin
            bad++; $display("FAIL init_row20 got cs=%b addr=%0d exp 1 20", bus.sram_cs, bus.sram_addr);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.sram_cs !== 1'b0) begin
            bad++; $display("FAIL init_rst_cs got=%b exp=0", bus.sram_cs);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            total++;
            if ({bus.req_ready, bus.sram_cs, bus.sram_addr} !== {1'b0, 1'b1, 6'(i)}) begin
                bad++;
                $display("FAIL init_restart_row%0d got rdy=%b cs=%b addr=%0d", i,
                         bus.req_ready, bus.sram_cs, bus.sram_addr);
            end
            step();
        end
        do_req(1'b0, 6'h3F, 64'h0, 8'h00, 10, w);
        idle();
        n = 0;
        while (got_q.size() < 1 && n < 20) begin step(); n++; end
        total++;
        if (got_q.size() < 1) begin
            bad++; $display("FAIL init_read_timeout got=0 responses exp=1");
        end else begin
            b = got_q.pop_front();
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            if (b.d !== 64'h0) begin
                bad++; $display("FAIL init_read_3f got=%h exp=0", b.d);
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = pat(i);
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
            ref_mem[i]  = '0;
`else
            ref_mem[i]  = pat(i);
`endif
        end
        idle();
        bus.rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
        test_init_restart();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/hpdcache_sram_wbe_ctrl.md
Name: hpdcache_sram_wbe_ctrl

Overview:
Initiator-side controller for a 1RW, byte-write-enable SRAM macro. It accepts read and write requests on a valid/ready port and drives one SRAM access per cycle (chip select, write enable, address, write data, byte enables). It captures the 1-cycle-latency read data into a 2-entry response buffer with its own valid/ready port. It sits between HPDcache data/dir access logic and the SRAM wrapper, so that back-pressure never loses read data.

Parameters:
ADDR_SIZE, 6, SRAM address width
DATA_SIZE, 64, bits per data word; must be a multiple of 8
DEPTH, 2**ADDR_SIZE, number of SRAM rows; DEPTH <= 2**ADDR_SIZE
NDATA, 1, words per SRAM row

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid & ready
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_SIZE  row address
req_wdata  in  NDATA*DATA_SIZE  write data
req_wbe  in  NDATA*DATA_SIZE/8  byte enables, one bit per byte
rsp_valid  out  1  read data available
rsp_ready  in  1  consumer takes read data
rsp_rdata  out  NDATA*DATA_SIZE  read data, oldest first
sram_cs  out  1  SRAM chip select
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_SIZE  SRAM address
sram_wdata  out  NDATA*DATA_SIZE  SRAM write data
sram_wbyteenable  out  NDATA*DATA_SIZE/8  SRAM byte enables
sram_rdata  in  NDATA*DATA_SIZE  SRAM read data, valid exactly one cycle after a read

Behaviour:
- SRAM outputs are combinational from the accepted request: sram_cs = req_valid & req_ready (or an init access). sram_we, sram_addr, sram_wdata and sram_wbyteenable pass through.
- Reads:
  - rd_inflight flop is set in the cycle after a read is accepted.
  - In that next cycle, sram_rdata is pushed into the response FIFO (2 entries, pointers plus a 2-bit count).
  - rsp_valid = count != 0, and it is registered, so an accepted read reaches rsp_valid 2 cycles later.
  - rsp_rdata = FIFO head. Pop on rsp_valid & rsp_ready.
- Read credit: a read may be accepted iff rd_inflight + count - pop < 2, where pop is the same-cycle pop. With rsp_ready held high this sustains 1 read per cycle.
- Writes are always accepted in the run state and do not consume credit.
- req_ready = run_state & (req_we | credit_ok). It must not depend on req_valid.
- Simultaneous push and pop: count is unchanged; head and tail pointers both advance and wrap at 2.
- The FIFO can never overflow by construction. Treat a push while count == 2 as a fatal assertion (simulation only).
- Ordering: accesses hit the SRAM in acceptance order. A read following a write to the same address returns the new data, guaranteed by the SRAM itself with no bypass.
- Reset values: count = 0, pointers = 0, rd_inflight = 0, rsp_valid = 0, req_ready = 0 during the reset cycle, sram_cs = 0. Reset discards any in-flight read and buffered data.

Optional Feature:
- HPDCACHE_SRAM_CTRL_INIT_EN defined:
  - After reset the FSM enters INIT.
  - It writes zero with all byte enables set to rows 0..DEPTH-1, one per cycle, using an ADDR_SIZE-bit counter.
  - req_ready = 0 throughout INIT.
  - After writing row DEPTH-1 the FSM moves to RUN.
  - Reset asserted mid-INIT restarts the sweep at row 0.
- Undefined: the FSM resets directly into RUN, no counter is instantiated, and SRAM contents are undefined.

Decomposition:
- Package hpdcache_sram_ctrl_pkg holds:
  - a state enum {INIT, RUN};
  - a localparam for response FIFO depth = 2;
  - a typedef for the packed row data and byte-enable types, parameterized through the module.
- One natural sub-module, hpdcache_sram_ctrl_rsp_fifo: a 2-entry registered FIFO with push, pop, count and head data. The controller instantiates the FIFO and contains the FSM and credit logic.

Test Plan:
- Write then read: write addr 0x05, data 0x1122334455667788, wbe 0xFF; then read 0x05 → rsp_valid 2 cycles after read acceptance, rsp_rdata = 0x1122334455667788.
- Partial write: after the above, write 0x05 with wdata 0xAAAA...AA and wbe 0x0F → read returns 0x11223344AAAAAAAA; sram_wbyteenable = 0x0F in the write cycle.
- Back-to-back reads, rsp_ready=1: reads at addresses 0,1,2,3 on consecutive cycles → req_ready stays 1 and 4 responses arrive in order on 4 consecutive cycles.
- Back-pressure with rsp_ready=0, 3 reads issued → only 2 accepted, req_ready=0 on the third while a write is still accepted. Raising rsp_ready → the two responses drain in order and the third read is then accepted.
- Reset mid-stream: assert rst one cycle after a read is accepted → rsp_valid=0 next cycle, no response ever emerges, count=0.
- With HPDCACHE_SRAM_CTRL_INIT_EN and DEPTH=64:
  - req_ready=0 for 64 cycles after reset, with sram_cs=1, sram_we=1, wbe all-ones and addr 0..63.
  - A subsequent read of 0x3F returns 0.
  - Reset asserted at init row 20 → the sweep restarts at 0.
